mips_mc_core: RTL and testbench
===============================

Name: mips_mc_core

Overview:
Parametrised multi-cycle MIPS-subset processor core, the successor to the fixed-width GPP. It fetches 32-bit instructions from external instruction memory over a req/ack handshake and executes them through WAIT/FETCH/DECODE/EXECUTE/STORE states. It owns the register file, the PC and a retired-instruction counter, and exposes a debug register read port for benches and upper-level integration.

Parameters:
DATA_W, 32, datapath/register width; legal range 16..64
NREG, 32, number of architectural registers; power of 2, at most 32; reg 0 hardwired to zero
IMEM_AW, 8, PC/instruction-address width, in words
RESET_PC, 0, PC value loaded on reset

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request, held until ack
imem_addr  out  IMEM_AW  word address; equals PC while imem_req is high
imem_ack  in  1  memory has imem_rdata valid this cycle
imem_rdata  in  32  instruction word
dbg_rsel  in  $clog2(NREG)  debug register select
dbg_rdata  out  DATA_W  combinational read of reg[dbg_rsel]
halted  out  1  core stopped (HALT opcode or trap)
illegal  out  1  sticky; unsupported op/fn seen
trap  out  1  sticky; overflow trap (OVF_TRAP_EN only, else tied 0)
instr_cnt  out  32  retired-instruction count

Behaviour:
- Reset (synchronous, Rst=1 at posedge): state=WAIT, PC=RESET_PC, all regs=0, IR=0, imem_req=0, halted=0, illegal=0, trap=0, instr_cnt=0. Reset overrides any state, including mid-fetch with req pending.
- State encoding: 3 bits. WAIT, FETCH, DECODE, EXECUTE, STORE, HALT.
- WAIT: 1 cycle, then FETCH.
- FETCH: imem_req=1 and imem_addr=PC. Stay in FETCH while imem_ack=0. On ack, IR<=imem_rdata and go to DECODE. imem_req drops in the cycle after ack. An ack while req=0 is ignored.
- DECODE: split IR into op[31:26], rs[25:21], rt[20:16], rd[15:11], sh[10:6], fn[5:0], imm[15:0]. Latch A=reg[rs], B=reg[rt]. Register indices are taken modulo NREG.
- EXECUTE: ALU result latched to R.
  - op 0: fn 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1/0).
  - op 8 addi: signed-extended imm. op 9 addiu: signed-extended imm, no overflow check.
  - op 0xC andi, 0xD ori: zero-extended imm.
  - op 4 beq: branch taken if A==B.
  - op 2 j: target = IR[IMEM_AW-1:0].
  - op 0x3F: halt.
  - Any other op, or any other fn under op 0: set illegal, no writeback, instruction still retires.
- Arithmetic: all operations are modulo 2^DATA_W. Signed overflow on add/sub/addi = operand signs equal and result sign differs.
- STORE: write R to rd (R-type) or rt (I-type). Writes to reg 0 are discarded.
  - PC update: PC+1; or PC+1+sext(imm) if beq taken; or the j target. All wrap modulo 2^IMEM_AW.
  - instr_cnt += 1, wraps at 2^32. Next state FETCH.
- Halt: op 0x3F goes to HALT from EXECUTE, no writeback, instr_cnt not incremented. HALT is absorbing until Rst; halted=1 in HALT.
- Latency: 4 cycles per instruction with zero-wait ack (FETCH, DECODE, EXECUTE, STORE). Each cycle of ack delay adds 1.
- dbg_rdata reflects a register write from the cycle after STORE.

Optional Feature:
OVF_TRAP_EN
- Defined: signed overflow on add/sub/addi suppresses writeback, sets trap=1, leaves PC and instr_cnt unchanged, and goes to HALT.
- Undefined: wrapped result is written normally and trap is tied to 0.

Decomposition:
- Package mips_mc_pkg: state enum, opcode constants (OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_ADDI=8, OP_ADDIU=9, OP_ANDI=0xC, OP_ORI=0xD, OP_HALT=0x3F), funct constants, ALU-op enum.
- One sub-module, mips_mc_regfile: NREG x DATA_W, two combinational read ports plus a debug read port, one synchronous write port, reg 0 forced to zero. The ALU stays inline.

Test Plan:
- Reset, then 0x20080001 (addi $8,$0,1), ack immediate -> reg8=1 four cycles after the first req; instr_cnt=1.
- Sequence addi $8=5, addi $9=3 (0x20090003), add $10,$8,$9 (0x01095020), then 0xFC000000 -> reg10=8, halted=1, instr_cnt=3, imem_req stays 0 afterwards.
- beq $8,$8,+2 (0x11080002) at PC=4 -> next imem_addr=7; with $8!=$9, beq $8,$9,+2 -> next imem_addr=5.
- imem_ack delayed 3 cycles -> imem_addr/imem_req held stable throughout; same result, +3 cycles.
- DATA_W=16: addi $8,$0,0x7FFF (0x20087FFF), then addi $8,$8,1 (0x21080001) -> with OVF_TRAP_EN: trap=1, halted=1, reg8=0x7FFF. Without: reg8=0x8000, trap=0.
- Op 0x3E, write to $0, Rst asserted during FETCH wait -> illegal=1 with regs unchanged; reg0 stays 0; reset returns to WAIT with PC=RESET_PC.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset core:
// FSM states, opcode/funct constants and the inline ALU operation set.
package mips_mc_pkg;

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_STORE   = 3'd4,
    S_HALT    = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

endpackage

// File: rtl/mips_mc_regfile.sv
// NREG x DATA_W register file: two operand read ports, one debug read port,
// one synchronous write port. Register 0 always reads as zero.
module mips_mc_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [$clog2(NREG)-1:0]   ra_sel,
  output logic [DATA_W-1:0]         ra_data,
  input  logic [$clog2(NREG)-1:0]   rb_sel,
  output logic [DATA_W-1:0]         rb_data,
  input  logic [$clog2(NREG)-1:0]   dbg_sel,
  output logic [DATA_W-1:0]         dbg_data,
  input  logic                      we,
  input  logic [$clog2(NREG)-1:0]   wsel,
  input  logic [DATA_W-1:0]         wdata
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[wsel] = wdata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data  = regs_q[ra_sel];
  assign rb_data  = regs_q[rb_sel];
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS-subset core: WAIT/FETCH/DECODE/EXECUTE/STORE/HALT.
// Define OVF_TRAP_EN to halt with trap=1 on signed add/sub/addi overflow.
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int IMEM_AW  = 8,
  parameter int RESET_PC = 0
) (
  input  logic                    Clk,
  input  logic                    Rst,
  output logic                    imem_req,
  output logic [IMEM_AW-1:0]      imem_addr,
  input  logic                    imem_ack,
  input  logic [31:0]             imem_rdata,
  input  logic [$clog2(NREG)-1:0] dbg_rsel,
  output logic [DATA_W-1:0]       dbg_rdata,
  output logic                    halted,
  output logic                    illegal,
  output logic                    trap,
  output logic [31:0]             instr_cnt
);

  localparam int RW = $clog2(NREG);
`ifdef OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [IMEM_AW-1:0]  pc_q, pc_d, npc_q, npc_d;
  logic [31:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
  logic                wen_q, wen_d;
  logic [RW-1:0]       wdst_q, wdst_d;
  logic                req_q, req_d, halted_q, halted_d;
  logic                illegal_q, illegal_d, trap_q, trap_d;
  logic [31:0]         cnt_q, cnt_d;

  logic [5:0]          op, fn;
  logic [RW-1:0]       rs, rt, rd;
  logic [15:0]         imm;
  logic [DATA_W-1:0]   simm, zimm, rf_a, rf_b;
  logic [IMEM_AW-1:0]  pc_inc, br_tgt;
  logic                rf_we;
  logic                unused_ir;

  assign op   = ir_q[31:26];
  assign fn   = ir_q[5:0];
  assign rs   = ir_q[21 +: RW];
  assign rt   = ir_q[16 +: RW];
  assign rd   = ir_q[11 +: RW];
  assign imm  = ir_q[15:0];
  assign simm = DATA_W'($signed(imm));
  assign zimm = DATA_W'(imm);
  assign unused_ir = ^ir_q;

  assign pc_inc = pc_q + IMEM_AW'(1);
  assign br_tgt = IMEM_AW'(32'(pc_q) + 32'd1 + 32'($signed(imm)));

  // Instruction decode and ALU; only consumed while in EXECUTE.
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_b, alu_y;
  logic              ovf_chk, ovf, wr_rd, writes, bad, halt_op, branch, jump;

  always_comb begin
    alu_op  = ALU_ADD;
    alu_b   = b_q;
    ovf_chk = 1'b0;
    wr_rd   = 1'b0;
    writes  = 1'b1;
    bad     = 1'b0;
    halt_op = 1'b0;
    branch  = 1'b0;
    jump    = 1'b0;
    case (op)
      OP_RTYPE: begin
        wr_rd = 1'b1;
        case (fn)
          FN_ADD:  ovf_chk = 1'b1;
          FN_SUB:  begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: begin bad = 1'b1; writes = 1'b0; end
        endcase
      end
      OP_ADDI:  begin alu_b = simm; ovf_chk = 1'b1; end
      OP_ADDIU: alu_b = simm;
      OP_ANDI:  begin alu_op = ALU_AND; alu_b = zimm; end
      OP_ORI:   begin alu_op = ALU_OR;  alu_b = zimm; end
      OP_BEQ:   begin writes = 1'b0; branch = 1'b1; end
      OP_J:     begin writes = 1'b0; jump = 1'b1; end
      OP_HALT:  begin writes = 1'b0; halt_op = 1'b1; end
      default:  begin writes = 1'b0; bad = 1'b1; end
    endcase

    alu_y = '0;
    case (alu_op)
      ALU_ADD: alu_y = a_q + alu_b;
      ALU_SUB: alu_y = a_q - alu_b;
      ALU_AND: alu_y = a_q & alu_b;
      ALU_OR:  alu_y = a_q | alu_b;
      ALU_SLT: alu_y = ($signed(a_q) < $signed(alu_b)) ? DATA_W'(1) : '0;
      default: alu_y = '0;
    endcase

    // Subtraction overflows when operand signs differ; addition when they match.
    ovf = ovf_chk
        && ((alu_op == ALU_SUB) ? (a_q[DATA_W-1] != alu_b[DATA_W-1])
                                : (a_q[DATA_W-1] == alu_b[DATA_W-1]))
        && (alu_y[DATA_W-1] != a_q[DATA_W-1]);
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    wen_d     = wen_q;
    wdst_d    = wdst_q;
    illegal_d = illegal_q;
    trap_d    = trap_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_WAIT:  state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_a;
        b_d     = rf_b;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        r_d    = alu_y;
        wen_d  = writes;
        wdst_d = wr_rd ? rd : rt;
        if (jump) begin
          npc_d = ir_q[IMEM_AW-1:0];
        end else if (branch && (a_q == b_q)) begin
          npc_d = br_tgt;
        end else begin
          npc_d = pc_inc;
        end
        if (bad) begin
          illegal_d = 1'b1;
        end
        if (halt_op) begin
          state_d = S_HALT;
        end else if (TRAP_EN && ovf) begin
          trap_d  = 1'b1;
          wen_d   = 1'b0;
          state_d = S_HALT;
        end else begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        pc_d    = npc_q;
        cnt_d   = cnt_q + 32'd1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_WAIT;
    endcase
    req_d    = (state_d == S_FETCH);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_WAIT;
      pc_q      <= IMEM_AW'(RESET_PC);
      npc_q     <= IMEM_AW'(RESET_PC);
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      wen_q     <= 1'b0;
      wdst_q    <= '0;
      req_q     <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      trap_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      npc_q     <= npc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      wen_q     <= wen_d;
      wdst_q    <= wdst_d;
      req_q     <= req_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      trap_q    <= trap_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rf_we = (state_q == S_STORE) && wen_q;

  mips_mc_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .Clk      (Clk),
    .Rst      (Rst),
    .ra_sel   (rs),
    .ra_data  (rf_a),
    .rb_sel   (rt),
    .rb_data  (rf_b),
    .dbg_sel  (dbg_rsel),
    .dbg_data (dbg_rdata),
    .we       (rf_we),
    .wsel     (wdst_q),
    .wdata    (r_q)
  );

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign trap      = trap_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench for mips_mc_core: a 32-bit core driven through several
// programs, plus a 16-bit core running an overflow program alongside.
module tb_mips_mc_core;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

`ifdef OVF_TRAP_EN
  localparam logic [15:0] E16_R8   = 16'h7FFF;
  localparam logic        E16_TRAP = 1'b1;
  localparam logic [31:0] E16_CNT  = 32'd2;
`else
  localparam logic [15:0] E16_R8   = 16'h8000;
  localparam logic        E16_TRAP = 1'b0;
  localparam logic [31:0] E16_CNT  = 32'd3;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit core
  logic        req, ack, halted, illegal, trap;
  logic [7:0]  addr;
  logic [31:0] rdata, dbg, cnt;
  logic [4:0]  rsel;

  // 16-bit core
  logic        req16, ack16, halted16, illegal16, trap16;
  logic [7:0]  addr16;
  logic [31:0] rdata16, cnt16;
  logic [15:0] dbg16;
  logic [4:0]  rsel16;

  logic [31:0] mem   [256];
  logic [31:0] mem16 [256];
  int          ack_dly;
  bit          stall_en;
  logic [7:0]  stall_addr;
  int          wcnt;

  logic [7:0]  fetch_q [$];
  logic [7:0]  exp_q [$];

  int n_total = 0;
  int n_bad   = 0;

  mips_mc_core dut (
    .Clk(clk), .Rst(rst), .imem_req(req), .imem_addr(addr), .imem_ack(ack),
    .imem_rdata(rdata), .dbg_rsel(rsel), .dbg_rdata(dbg), .halted(halted),
    .illegal(illegal), .trap(trap), .instr_cnt(cnt)
  );

  mips_mc_core #(.DATA_W(16)) dut16 (
    .Clk(clk), .Rst(rst), .imem_req(req16), .imem_addr(addr16), .imem_ack(ack16),
    .imem_rdata(rdata16), .dbg_rsel(rsel16), .dbg_rdata(dbg16), .halted(halted16),
    .illegal(illegal16), .trap(trap16), .instr_cnt(cnt16)
  );

  // instruction memory responder for the 32-bit core (delay / stall control)
  initial begin
    ack = 1'b0; rdata = '0; wcnt = 0;
    forever begin
      @(negedge clk);
      if (req && !ack && !(stall_en && addr == stall_addr)) begin
        if (wcnt >= ack_dly) begin
          ack = 1'b1; rdata = mem[addr]; fetch_q.push_back(addr); wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        ack = 1'b0;
        if (!req) wcnt = 0;
      end
    end
  end

  // zero-wait responder for the 16-bit core
  initial begin
    ack16 = 1'b0; rdata16 = '0;
    forever begin
      @(negedge clk);
      if (req16 && !ack16) begin
        ack16 = 1'b1; rdata16 = mem16[addr16];
      end else begin
        ack16 = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    fetch_q.delete();
    rst = 1'b0;
  endtask

  task automatic rd32(input int r, output logic [31:0] v);
    rsel = 5'(r);
    #1;
    v = dbg;
  endtask

  task automatic wait_req(input string tag);
    int i;
    for (i = 0; i < 50 && !req; i++) @(negedge clk);
    check(tag, {63'd0, req}, 64'd1);
  endtask

  task automatic wait_halt(input string tag);
    int i;
    for (i = 0; i < 400 && !halted; i++) @(negedge clk);
    check(tag, {63'd0, halted}, 64'd1);
  endtask

  task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
    logic [31:0] v;
    rd32(r, v);
    check(tag, 64'(v), 64'(exp));
  endtask

  initial begin
    logic [31:0] v;
    bit          stable;
    bit          any_req;
    int          i;

    for (int k = 0; k < 256; k++) mem16[k] = HALT_W;
    mem16[0] = 32'h2008_7FFF;  // addi  $8,$0,0x7FFF
    mem16[1] = 32'h2509_0001;  // addiu $9,$8,1  (wraps, never traps)
    mem16[2] = 32'h2108_0001;  // addi  $8,$8,1  (signed overflow)
    mem16[3] = HALT_W;
    rsel = 5'd0; rsel16 = 5'd0; ack_dly = 0; stall_en = 1'b0; stall_addr = '0;

    // --- single addi, zero-wait ack: latency and reset state
    clear_mem();
    mem[0] = 32'h2008_0001;
    do_reset();
    check("rst_req", {63'd0, req}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_illegal", {63'd0, illegal}, 64'd0);
    check("rst_trap", {63'd0, trap}, 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    rsel = 5'd8;
    wait_req("s1_first_req");
    check("s1_first_addr", 64'(addr), 64'd0);
    repeat (3) @(negedge clk);
    check("s1_r8_before", 64'(dbg), 64'd0);
    @(negedge clk);
    check("s1_r8_after4", 64'(dbg), 64'd1);
    check("s1_cnt", 64'(cnt), 64'd1);
    wait_halt("s1_halt");
    check("s1_cnt_halt", 64'(cnt), 64'd1);

    // --- 16-bit core, overflow behaviour
    for (i = 0; i < 100 && !halted16; i++) @(negedge clk);
    check("w16_halted", {63'd0, halted16}, 64'd1);
    rsel16 = 5'd8; #1;
    check("w16_r8", 64'(dbg16), 64'(E16_R8));
    rsel16 = 5'd9; #1;
    check("w16_r9_addiu", 64'(dbg16), 64'h8000);
    check("w16_trap", {63'd0, trap16}, {63'd0, E16_TRAP});
    check("w16_cnt", 64'(cnt16), 64'(E16_CNT));

    // --- addi/addi/add then halt
    clear_mem();
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    mem[2] = 32'h0109_5020;
    mem[3] = HALT_W;
    do_reset();
    wait_halt("s2_halt");
    chk_reg("s2_r10", 10, 32'd8);
    chk_reg("s2_r8", 8, 32'd5);
    check("s2_cnt", 64'(cnt), 64'd3);
    any_req = 1'b0;
    repeat (5) begin @(negedge clk); any_req |= req; end
    check("s2_req_idle", {63'd0, any_req}, 64'd0);

    // --- branches, jump, sub/slt/or/and/ori/andi with fetch-address scoreboard
    clear_mem();
    mem[0]  = 32'h2008_0005;  // addi $8,$0,5
    mem[1]  = 32'h2009_0003;  // addi $9,$0,3
    mem[2]  = 32'h340B_00F0;  // ori  $11,$0,0xF0
    mem[3]  = 32'h310C_0004;  // andi $12,$8,4
    mem[4]  = 32'h1108_0002;  // beq  $8,$8,+2  -> 7
    mem[7]  = 32'h1109_0002;  // beq  $8,$9,+2  -> 8 (not taken)
    mem[8]  = 32'h0800_000C;  // j    12
    mem[12] = 32'h0128_6822;  // sub  $13,$9,$8
    mem[13] = 32'h01A9_702A;  // slt  $14,$13,$9
    mem[14] = 32'h016C_7825;  // or   $15,$11,$12
    mem[15] = 32'h01E8_8024;  // and  $16,$15,$8
    mem[16] = HALT_W;
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
    do_reset();
    wait_halt("s3_halt");
    check("s3_fetch_count", 64'(fetch_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && fetch_q.size() > 0)
      check("s3_fetch_addr", 64'(fetch_q.pop_front()), 64'(exp_q.pop_front()));
    chk_reg("s3_ori", 11, 32'h0000_00F0);
    chk_reg("s3_andi", 12, 32'h0000_0004);
    chk_reg("s3_sub", 13, 32'hFFFF_FFFE);
    chk_reg("s3_slt", 14, 32'd1);
    chk_reg("s3_or", 15, 32'h0000_00F4);
    chk_reg("s3_and", 16, 32'h0000_0004);
    check("s3_cnt", 64'(cnt), 64'd11);

    // --- ack delayed 3 cycles
    clear_mem();
    mem[0] = 32'h2008_0001;
    ack_dly = 3;
    do_reset();
    rsel = 5'd8;
    wait_req("s4_first_req");
    stable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!(req === 1'b1 && addr === 8'd0)) stable = 1'b0;
    end
    check("s4_req_addr_stable", {63'd0, stable}, 64'd1);
    repeat (3) @(negedge clk);
    check("s4_r8_before", 64'(dbg), 64'd0);
    @(negedge clk);
    check("s4_r8_after7", 64'(dbg), 64'd1);
    ack_dly = 0;
    wait_halt("s4_halt");

    // --- illegal op/funct and write to $0
    clear_mem();
    mem[0] = 32'h2008_0001;  // addi $8,$0,1
    mem[1] = 32'h2000_0007;  // addi $0,$0,7 (discarded)
    mem[2] = 32'hF808_0009;  // op 0x3E
    mem[3] = 32'h0129_4021;  // op 0 fn 0x21
    mem[4] = HALT_W;
    do_reset();
    wait_halt("s5_halt");
    check("s5_illegal", {63'd0, illegal}, 64'd1);
    chk_reg("s5_r0", 0, 32'd0);
    chk_reg("s5_r8", 8, 32'd1);
    check("s5_cnt", 64'(cnt), 64'd4);
    check("s5_trap", {63'd0, trap}, 64'd0);

    // --- reset while a fetch is pending
    mem[2] = 32'h2008_0009;
    stall_en = 1'b1; stall_addr = 8'd2;
    do_reset();
    check("s6_illegal_cleared", {63'd0, illegal}, 64'd0);
    check("s6_halted_cleared", {63'd0, halted}, 64'd0);
    for (i = 0; i < 50 && !(req && addr == 8'd2); i++) @(negedge clk);
    check("s6_stalled_at_2", {63'd0, (req && addr == 8'd2)}, 64'd1);
    repeat (3) @(negedge clk);
    check("s6_still_req", {63'd0, req}, 64'd1);
    do_reset();
    stall_en = 1'b0;
    check("s6_req_after_rst", {63'd0, req}, 64'd0);
    check("s6_cnt_after_rst", 64'(cnt), 64'd0);
    chk_reg("s6_r8_after_rst", 8, 32'd0);
    @(negedge clk);
    check("s6_refetch_req", {63'd0, req}, 64'd1);
    check("s6_refetch_pc", 64'(addr), 64'd0);
    wait_halt("s6_halt");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
